// File: rtl/decode_stage_hz.sv
// MIPS decode stage: control decode, register bank with optional write-through
// bypass, immediate/branch-target generation, load-use stall and ID/EX register.
module decode_stage_hz #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZEOP     = 6,
    parameter int NREGS      = 32,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_instruccion,
    input  logic [DATA_WIDTH-1:0] i_currentpc,
    input  logic                  i_flush,
    input  logic                  i_regwrite,
    input  logic [4:0]            i_rt_rd,
    input  logic [DATA_WIDTH-1:0] i_writedata,
    output logic                  o_stall,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_regA,
    output logic [DATA_WIDTH-1:0] o_regB,
    output logic [DATA_WIDTH-1:0] o_extendido,
    output logic [DATA_WIDTH-1:0] o_pcbranch,
    output logic [SIZEOP-1:0]     o_opcode,
    output logic [4:0]            o_rs,
    output logic [4:0]            o_rt,
    output logic [4:0]            o_rd,
    output logic [3:0]            o_ex,
    output logic [2:0]            o_mem,
    output logic [1:0]            o_wb
);

    localparam int AW = $clog2(NREGS);

    localparam logic [SIZEOP-1:0] OP_RTYPE = SIZEOP'(6'h00);
    localparam logic [SIZEOP-1:0] OP_LW    = SIZEOP'(6'h23);
    localparam logic [SIZEOP-1:0] OP_SW    = SIZEOP'(6'h2B);
    localparam logic [SIZEOP-1:0] OP_BEQ   = SIZEOP'(6'h04);
    localparam logic [SIZEOP-1:0] OP_ADDI  = SIZEOP'(6'h08);

    logic [DATA_WIDTH-1:0] r_bank [NREGS];

    logic [SIZEOP-1:0]     w_opcode;
    logic [4:0]            w_rs;
    logic [4:0]            w_rt;
    logic [4:0]            w_rd;
    logic [AW-1:0]         w_rs_a;
    logic [AW-1:0]         w_rt_a;
    logic [AW-1:0]         w_wr_a;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;
    logic [DATA_WIDTH-1:0] w_ext;
    logic [DATA_WIDTH-1:0] w_pcbranch;
    logic [3:0]            w_ex;
    logic [2:0]            w_mem;
    logic [1:0]            w_wb;
    logic                  w_bubble;
    logic                  w_unused_hi;

    assign w_opcode = i_instruccion[DATA_WIDTH-1 -: SIZEOP];
    assign w_rs     = i_instruccion[25:21];
    assign w_rt     = i_instruccion[20:16];
    assign w_rd     = i_instruccion[15:11];
    assign w_rs_a   = w_rs[AW-1:0];
    assign w_rt_a   = w_rt[AW-1:0];
    assign w_wr_a   = i_rt_rd[AW-1:0];
    assign w_wr_en  = i_regwrite && (w_wr_a != '0);
    // Upper write-address bits are ignored when the bank is smaller than 32 entries.
    assign w_unused_hi = &{1'b0, i_rt_rd};

    // Register 0 is hardwired to zero; bypass returns the value being written this cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_rd_a = '0;
        w_rd_b = '0;
        if (w_rs_a != '0) begin
            if (BYPASS && w_wr_en && (w_wr_a == w_rs_a)) w_rd_a = i_writedata;
            else                                         w_rd_a = r_bank[w_rs_a];
        end
        if (w_rt_a != '0) begin
            if (BYPASS && w_wr_en && (w_wr_a == w_rt_a)) w_rd_b = i_writedata;
            else                                         w_rd_b = r_bank[w_rt_a];
        end
    end

    assign w_ext      = {{(DATA_WIDTH-16){i_instruccion[15]}}, i_instruccion[15:0]};
    assign w_pcbranch = i_currentpc + (w_ext << 2);

    always_comb begin
        w_ex  = 4'b0000;
        w_mem = 3'b000;
        w_wb  = 2'b00;
        case (w_opcode)
            OP_RTYPE: begin w_ex = 4'b1010; w_mem = 3'b000; w_wb = 2'b10; end
            OP_LW:    begin w_ex = 4'b0100; w_mem = 3'b010; w_wb = 2'b11; end
            OP_SW:    begin w_ex = 4'b0100; w_mem = 3'b001; w_wb = 2'b00; end
            OP_BEQ:   begin w_ex = 4'b0001; w_mem = 3'b100; w_wb = 2'b00; end
            OP_ADDI:  begin w_ex = 4'b0100; w_mem = 3'b000; w_wb = 2'b10; end
            default:  begin w_ex = 4'b0000; w_mem = 3'b000; w_wb = 2'b00; end
        endcase
    end

    // Load in ID/EX whose destination feeds the decoding instruction; a flush overrides it.
    assign o_stall = !i_flush && o_valid && o_mem[1] && i_valid && (o_rt != 5'd0)
                     && ((o_rt == w_rs) || (o_rt == w_rt));

    assign w_bubble = o_stall || i_flush || !i_valid;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            // NOTE: the bank is a real register file that must read zero after reset, so every entry is cleared.
            for (int i = 0; i < NREGS; i++) r_bank[i] <= '0;
        end else if (w_wr_en) begin
            // NOTE: sequential state always uses non-blocking assignment so all flops update together.
            r_bank[w_wr_a] <= i_writedata;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_valid     <= 1'b0;
            o_regA      <= '0;
            o_regB      <= '0;
            o_extendido <= '0;
            o_pcbranch  <= '0;
            o_opcode    <= '0;
            o_rs        <= '0;
            o_rt        <= '0;
            o_rd        <= '0;
            o_ex        <= '0;
            o_mem       <= '0;
            o_wb        <= '0;
        end else begin
            o_valid     <= !w_bubble;
            o_ex        <= w_bubble ? 4'b0000 : w_ex;
            o_mem       <= w_bubble ? 3'b000  : w_mem;
            o_wb        <= w_bubble ? 2'b00   : w_wb;
            o_regA      <= w_rd_a;
            o_regB      <= w_rd_b;
            o_extendido <= w_ext;
            o_pcbranch  <= w_pcbranch;
            o_opcode    <= w_opcode;
            o_rs        <= w_rs;
            o_rt        <= w_rt;
            o_rd        <= w_rd;
        end
    end

endmodule
